// File: rtl/display_frame_writer.sv
// display_frame_writer: SPI slave that takes a draw command, then streams
// one byte per pixel into a framebuffer write port in raster order.
module display_frame_writer #(
  parameter int unsigned ROWS     = 168,
  parameter int unsigned COLS     = 144,
  parameter logic [7:0]  CMD_DRAW = 8'h05
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic        fb_we,
  output logic [14:0] fb_addr,
  output logic [7:0]  fb_wdata,
  output logic        frame_done,
  output logic        intn,
  output logic        busy,
  output logic        error
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    ARMED,
    DATA
  } state_e;

  logic [1:0] cs_sq;
  logic [1:0] sck_sq;
  logic [1:0] mosi_sq;
  logic       cs_d1_q;
  logic       sck_d1_q;

  logic       cs_s;
  logic       sck_s;
  logic       mosi_s;
  logic       cs_fall;
  logic       cs_rise;
  logic       sck_rise;
  logic       sck_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sq    <= 2'b11;
      sck_sq   <= 2'b00;
      mosi_sq  <= 2'b00;
      cs_d1_q  <= 1'b1;
      sck_d1_q <= 1'b0;
    end else begin
      cs_sq    <= {cs_sq[0], cs};
      sck_sq   <= {sck_sq[0], sck};
      mosi_sq  <= {mosi_sq[0], mosi};
      cs_d1_q  <= cs_sq[1];
      sck_d1_q <= sck_sq[1];
    end
  end

  assign cs_s     = cs_sq[1];
  assign sck_s    = sck_sq[1];
  assign mosi_s   = mosi_sq[1];
  assign cs_fall  = cs_d1_q & ~cs_s;
  assign cs_rise  = ~cs_d1_q & cs_s;
  assign sck_rise = ~sck_d1_q & sck_s & ~cs_s;
  assign sck_fall = sck_d1_q & ~sck_s & ~cs_s;

  // 7-bit right shifter: after seven bits it holds bits 0..6, the
  // eighth bit is taken straight from the synchronizer.
  logic [2:0] bit_q;
  logic [6:0] sh_q;
  logic       byte_done;
  logic [7:0] byte_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_q <= 3'd0;
      sh_q  <= 7'd0;
    end else if (cs_fall || cs_rise) begin
      bit_q <= 3'd0;
    end else if (sck_rise) begin
      bit_q <= bit_q + 3'd1;
      sh_q  <= {mosi_s, sh_q[6:1]};
    end
  end

  assign byte_done = sck_rise & (bit_q == 3'd7) & ~cs_fall;
  assign byte_w    = {mosi_s, sh_q};

  state_e        st_q;
  logic          cmd_seen_q;
  logic          cmd_ok_q;
  logic          last_q;
  logic          fin_q;
  logic [7:0]    stat_q;
  logic [2:0]    mbit_q;
  logic [2:0]    mnext;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [14:0]   addr_q;
  logic          miso_q;
  logic          fb_we_q;
  logic [14:0]   fb_addr_q;
  logic [7:0]    fb_wdata_q;
  logic          frame_done_q;
  logic          intn_q;
  logic          busy_q;
  logic          err_q;

  assign mnext = mbit_q + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q         <= IDLE;
      cmd_seen_q   <= 1'b0;
      cmd_ok_q     <= 1'b0;
      last_q       <= 1'b0;
      fin_q        <= 1'b0;
      stat_q       <= 8'd0;
      mbit_q       <= 3'd0;
      row_q        <= '0;
      col_q        <= '0;
      addr_q       <= 15'd0;
      miso_q       <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= 15'd0;
      fb_wdata_q   <= 8'd0;
      frame_done_q <= 1'b0;
      intn_q       <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      fin_q        <= 1'b0;
      miso_q       <= 1'b0;
      if (fin_q) begin
        frame_done_q <= 1'b1;
        busy_q       <= 1'b0;
        intn_q       <= 1'b0;
      end
      if (cs_fall) begin
        intn_q <= 1'b1;
      end
      unique case (st_q)
        IDLE: begin
          if (cs_fall) begin
            st_q       <= CMD;
            cmd_seen_q <= 1'b0;
            cmd_ok_q   <= 1'b0;
            mbit_q     <= 3'd0;
            stat_q     <= {5'b0, ~intn_q, err_q, busy_q};
            miso_q     <= busy_q;
          end
        end
        CMD: begin
          if (cs_rise) begin
            st_q <= (cmd_seen_q && cmd_ok_q) ? ARMED : IDLE;
          end else begin
            miso_q <= stat_q[mbit_q];
            if (sck_fall) begin
              mbit_q <= mnext;
              miso_q <= stat_q[mnext];
            end
            if (byte_done && !cmd_seen_q) begin
              cmd_seen_q <= 1'b1;
              if (byte_w == CMD_DRAW) begin
                cmd_ok_q <= 1'b1;
                busy_q   <= 1'b1;
                err_q    <= 1'b0;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
        end
        ARMED: begin
          if (cs_fall) begin
            st_q   <= DATA;
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= 15'd0;
            last_q <= 1'b0;
          end
        end
        DATA: begin
          if (cs_rise) begin
            st_q <= IDLE;
            if (!last_q) begin
              err_q  <= 1'b1;
              busy_q <= 1'b0;
            end
          end else if (byte_done && !last_q) begin
            fb_we_q    <= 1'b1;
            fb_addr_q  <= addr_q;
            fb_wdata_q <= byte_w;
            addr_q     <= addr_q + 15'd1;
            if (col_q == COL_LAST) begin
              col_q <= '0;
              if (row_q == ROW_LAST) begin
                last_q <= 1'b1;
                fin_q  <= 1'b1;
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
      endcase
    end
  end

  assign miso       = miso_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign frame_done = frame_done_q;
  assign intn       = intn_q;
  assign busy       = busy_q;
  assign error      = err_q;

endmodule
